// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers for the AES MixColumns datapath and the shared FSM state type.
// Multiples are built from xtime chains so every product stays a small XOR tree.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (AES_POLY & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (byte 0 = MSB byte).
// With INV_EN=0 the inverse matrix is not built and the result is always forward.
module mix_column_word #(
    parameter bit INV_EN = 1'b1
) (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);
    import aes_gf_pkg::*;

    logic [7:0] b0, b1, b2, b3;
    logic [31:0] fwd_res;

    assign b0 = col[31:24];
    assign b1 = col[23:16];
    assign b2 = col[15:8];
    assign b3 = col[7:0];

    assign fwd_res = {
        gmul2(b0) ^ gmul3(b1) ^ b2        ^ b3,
        b0        ^ gmul2(b1) ^ gmul3(b2) ^ b3,
        b0        ^ b1        ^ gmul2(b2) ^ gmul3(b3),
        gmul3(b0) ^ b1        ^ b2        ^ gmul2(b3)
    };

    generate
        if (INV_EN) begin : g_inv
            logic [31:0] inv_res;
            assign inv_res = {
                gmul14(b0) ^ gmul11(b1) ^ gmul13(b2) ^ gmul9(b3),
                gmul9(b0)  ^ gmul14(b1) ^ gmul11(b2) ^ gmul13(b3),
                gmul13(b0) ^ gmul9(b1)  ^ gmul14(b2) ^ gmul11(b3),
                gmul11(b0) ^ gmul13(b1) ^ gmul9(b2)  ^ gmul14(b3)
            };
            assign res = inv ? inv_res : fwd_res;
        end else begin : g_fwd_only
            logic unused_inv;
            assign unused_inv = inv;
            assign res = fwd_res;
        end
    endgenerate

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns engine: transforms COLS_PER_CYCLE columns per clock
// between a valid/ready input and a valid/ready output.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic         i_inv,
    input  logic [127:0] i_block,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [127:0] o_block
);
    import aes_gf_pkg::*;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    state_t         state_reg;
    logic [1:0]     col_idx_reg;
    logic [127:0]   work_reg;
    logic           mode_reg;
    logic           o_valid_reg;

    logic [127:0]   work_next;
    logic [31:0]    work_cols [4];
    logic [31:0]    cols_next [4];
    logic [1:0]     col_sel   [COLS_PER_CYCLE];
    logic [31:0]    col_in    [COLS_PER_CYCLE];
    logic [31:0]    col_out   [COLS_PER_CYCLE];
    logic           accept;

    // i_ready only looks through to o_ready while a result is waiting to leave.
    assign i_ready = (state_reg == IDLE) || (state_reg == DONE && o_ready);
    assign accept  = i_valid && i_ready;
    assign o_valid = o_valid_reg;
    assign o_block = work_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cols
            assign work_cols[gi]               = work_reg[127 - 32*gi -: 32];
            assign work_next[127 - 32*gi -: 32] = cols_next[gi];
        end

        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lanes
            assign col_sel[gi] = col_idx_reg + 2'(gi);
            assign col_in[gi]  = work_cols[col_sel[gi]];

            mix_column_word #(
                .INV_EN (INV_EN)
            ) u_word (
                .col (col_in[gi]),
                .inv (mode_reg),
                .res (col_out[gi])
            );
        end
    endgenerate

    // Columns outside the current pass window keep their stored value.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cols_next[c] = work_cols[c];
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                if (col_sel[g] == 2'(c)) begin
                    cols_next[c] = col_out[g];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            col_idx_reg <= 2'd0;
            work_reg    <= 128'd0;
            mode_reg    <= 1'b0;
            o_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    work_reg    <= work_next;
                    col_idx_reg <= col_idx_reg + STEP;
                    if (col_idx_reg == LAST_IDX) begin
                        state_reg   <= DONE;
                        o_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid_reg <= 1'b0;
                        state_reg   <= accept ? BUSY : IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    o_valid_reg <= 1'b0;
                end
            endcase

            // accept is never true in BUSY, so this cannot collide with the pass update.
            if (accept) begin
                work_reg    <= i_block;
                mode_reg    <= i_inv & INV_EN;
                col_idx_reg <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: four instances (1/2/4 columns per cycle, and one with
// the inverse path removed) checked against a matrix-over-GF(2^8) reference model.
module tb_mix_columns_iter;

    localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] BB_IN0  = {4{32'hc6c6c6c6}};
    localparam logic [127:0] BB_OUT0 = {4{32'hc6c6c6c6}};
    localparam logic [127:0] BB_IN1  = {4{32'hd4d4d4d5}};
    localparam logic [127:0] BB_OUT1 = {4{32'hd5d5d7d6}};
    localparam logic [127:0] ONES    = {4{32'h01010101}};

    logic         clk = 1'b0;
    logic [3:0]   rst_v;
    logic [3:0]   iv;
    logic [3:0]   ir;
    logic [3:0]   inv;
    logic [3:0]   ov;
    logic [3:0]   ovr;
    logic [127:0] ib [4];
    logic [127:0] ob [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            mix_columns_iter #(
                .COLS_PER_CYCLE ((gi == 0) ? 1 : (gi == 1) ? 2 : 4),
                .INV_EN         (gi != 3)
            ) u_dut (
                .clk     (clk),
                .rst     (rst_v[gi]),
                .i_valid (iv[gi]),
                .i_ready (ir[gi]),
                .i_inv   (inv[gi]),
                .i_block (ib[gi]),
                .o_valid (ov[gi]),
                .o_ready (ovr[gi]),
                .o_block (ob[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 2 : 1;
    endfunction

    // Reference: generic GF(2^8) multiply and a rotated coefficient matrix.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] blk, input bit inv_b);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv_b) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gm(coef[(k - r + 4) % 4], blk[127 - 32*c - 8*k -: 8]);
                end
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one block, wait for acceptance, scramble inputs, then count cycles to o_valid.
    task automatic send(input int d, input logic [127:0] blk, input bit inv_b, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        iv[d]  = 1'b1;
        ib[d]  = blk;
        inv[d] = inv_b;
        while (!ir[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        iv[d]  = 1'b0;
        ib[d]  = rand_blk();
        inv[d] = ~inv_b;
        lat = 0;
        while (!ov[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("txn dut=%0d inv=%0d in=%h out=%h lat=%0d", d, inv_b, blk, ob[d], lat);
    endtask

    task automatic test_reset();
        rst_v = 4'hf;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || ob[d] !== 128'd0) begin
                failures++;
                $display("FAIL reset dut=%0d got ir=%b ov=%b ob=%h exp ir=1 ov=0 ob=0", d, ir[d], ov[d], ob[d]);
            end
        end
        @(negedge clk);
        rst_v = 4'h0;
    endtask

    task automatic test_fwd_vector();
        int lat;
        for (int d = 0; d < 3; d++) begin
            send(d, VEC_A, 1'b0, lat);
            checks++;
            if (ob[d] !== VEC_B || lat !== lat_of(d)) begin
                failures++;
                $display("FAIL fwd_vector dut=%0d got %h lat=%0d exp %h lat=%0d", d, ob[d], lat, VEC_B, lat_of(d));
            end
        end
    endtask

    task automatic test_inv_vector();
        int lat;
        for (int d = 0; d < 3; d++) begin
            send(d, VEC_B, 1'b1, lat);
            checks++;
            if (ob[d] !== VEC_A || lat !== lat_of(d)) begin
                failures++;
                $display("FAIL inv_vector dut=%0d got %h lat=%0d exp %h lat=%0d", d, ob[d], lat, VEC_A, lat_of(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            iv[d]  = 1'b1;
            ib[d]  = BB_IN0;
            inv[d] = 1'b0;
            checks++;
            if (ir[d] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_idle_ready dut=%0d got %b exp 1", d, ir[d]);
            end
            @(posedge clk);
            #1;
            ib[d] = BB_IN1;
            t = 0;
            while (!ov[d] && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            checks++;
            if (t !== lat_of(d) || ob[d] !== BB_OUT0 || ir[d] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_first dut=%0d got lat=%0d ob=%h ir=%b exp lat=%0d ob=%h ir=1",
                         d, t, ob[d], ir[d], lat_of(d), BB_OUT0);
            end
            $display("txn dut=%0d inv=0 in=%h out=%h lat=%0d", d, BB_IN0, ob[d], t);
            @(posedge clk);
            #1;
            iv[d] = 1'b0;
            ib[d] = rand_blk();
            t = 0;
            while (!ov[d] && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            checks++;
            if (t + 1 !== lat_of(d) + 1 || ob[d] !== BB_OUT1) begin
                failures++;
                $display("FAIL b2b_second dut=%0d got period=%0d ob=%h exp period=%0d ob=%h",
                         d, t + 1, ob[d], lat_of(d) + 1, BB_OUT1);
            end
            $display("txn dut=%0d inv=0 in=%h out=%h lat=%0d", d, BB_IN1, ob[d], t);
            @(posedge clk);
            #1;
            checks++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_drain dut=%0d got ov=%b ir=%b exp ov=0 ir=1", d, ov[d], ir[d]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] blk;
        logic [127:0] exp_res;
        for (int d = 0; d < 3; d++) begin
            blk     = rand_blk();
            exp_res = ref_mix(blk, 1'b0);
            ovr[d]  = 1'b0;
            send(d, blk, 1'b0, lat);
            iv[d]  = 1'b1;
            ib[d]  = rand_blk();
            inv[d] = 1'b1;
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (ov[d] !== 1'b1 || ob[d] !== exp_res || ir[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL backpressure_hold dut=%0d cyc=%0d got ov=%b ir=%b ob=%h exp ov=1 ir=0 ob=%h",
                             d, c, ov[d], ir[d], ob[d], exp_res);
                end
                @(posedge clk);
                #1;
            end
            ovr[d] = 1'b1;
            iv[d]  = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_release dut=%0d got ov=%b ir=%b exp ov=0 ir=1", d, ov[d], ir[d]);
            end
            repeat (lat_of(d) + 1) @(posedge clk);
            #1;
            checks++;
            if (ov[d] !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_no_extra dut=%0d got ov=%b exp 0", d, ov[d]);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        @(negedge clk);
        iv[0]  = 1'b1;
        ib[0]  = rand_blk();
        inv[0] = 1'b0;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || ob[0] !== 128'd0 || ir[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy got ov=%b ob=%h ir=%b exp ov=0 ob=0 ir=1", ov[0], ob[0], ir[0]);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_busy_stale got ov=%b exp 0", ov[0]);
        end
        send(0, ONES, 1'b0, lat);
        checks++;
        if (ob[0] !== ONES || lat !== 4) begin
            failures++;
            $display("FAIL reset_mid_busy_next got %h lat=%0d exp %h lat=4", ob[0], lat, ONES);
        end
    endtask

    task automatic test_random_roundtrip();
        int lat;
        int d;
        logic [127:0] blk;
        logic [127:0] mid;
        for (int i = 0; i < 1000; i++) begin
            d   = i % 3;
            blk = rand_blk();
            send(d, blk, 1'b0, lat);
            mid = ob[d];
            checks++;
            if (mid !== ref_mix(blk, 1'b0) || lat !== lat_of(d)) begin
                failures++;
                $display("FAIL random_fwd dut=%0d in=%h got %h lat=%0d exp %h lat=%0d",
                         d, blk, mid, lat, ref_mix(blk, 1'b0), lat_of(d));
            end
            send(d, mid, 1'b1, lat);
            checks++;
            if (ob[d] !== blk || lat !== lat_of(d)) begin
                failures++;
                $display("FAIL random_inv dut=%0d in=%h got %h lat=%0d exp %h lat=%0d",
                         d, mid, ob[d], lat, blk, lat_of(d));
            end
        end
    endtask

    task automatic test_inv_disabled();
        int lat;
        logic [127:0] blk;
        for (int i = 0; i < 100; i++) begin
            blk = (i == 0) ? VEC_A : rand_blk();
            send(3, blk, 1'b1, lat);
            checks++;
            if (ob[3] !== ref_mix(blk, 1'b0) || lat !== 1) begin
                failures++;
                $display("FAIL inv_disabled in=%h got %h lat=%0d exp %h lat=1",
                         blk, ob[3], lat, ref_mix(blk, 1'b0));
            end
        end
    endtask

    initial begin
        rst_v = 4'hf;
        iv    = 4'h0;
        inv   = 4'h0;
        ovr   = 4'hf;
        for (int d = 0; d < 4; d++) ib[d] = 128'd0;

        test_reset();
        test_fwd_vector();
        test_inv_vector();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_busy();
        test_random_roundtrip();
        test_inv_disabled();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
